// File: rtl/mipi_rx_word_align_pkg.sv
// Shared types and constants for the MIPI HS receive word aligner.
// Holds the aligner state encoding, the default sync pattern and the bit-offset width.
package mipi_rx_word_align_pkg;

  localparam logic [7:0]  SyncByteDefault = 8'hB8;
  localparam int unsigned OffsetW         = 3;

  typedef enum logic [1:0] {
    StIdle,
    StLpWait,
    StHunt,
    StLocked
  } state_e;

  // True when a and b differ in exactly one bit position.
  function automatic logic one_bit_off(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] d;
    d = a ^ b;
    return (d != 8'h00) && ((d & (d - 8'h01)) == 8'h00);
  endfunction

endpackage

// File: rtl/mipi_rx_sync_match.sv
// Searches the 16-bit byte window for the HS sync pattern at offsets 0..7, lowest offset wins.
// Single-bit-error tolerant search is compiled in with MIPI_RX_WORD_ALIGN_SOT_CORR_EN.
module mipi_rx_sync_match
  import mipi_rx_word_align_pkg::*;
(
  input  logic [15:0]        win,
  input  logic [7:0]         sync_byte,
  output logic               hit,
  output logic               corr,
  output logic [OffsetW-1:0] k
);

  logic               exact_hit;
  logic [OffsetW-1:0] exact_k;
  logic               near_hit;
  logic [OffsetW-1:0] near_k;

  always_comb begin
    exact_hit = 1'b0;
    exact_k   = '0;
    near_hit  = 1'b0;
    near_k    = '0;
    hit       = 1'b0;
    corr      = 1'b0;
    k         = '0;

    // Scan downwards so the last assignment belongs to the lowest offset.
    for (int i = 7; i >= 0; i--) begin
      if (win[i +: 8] == sync_byte) begin
        exact_hit = 1'b1;
        exact_k   = OffsetW'(i);
      end
    end

`ifdef MIPI_RX_WORD_ALIGN_SOT_CORR_EN
    for (int i = 7; i >= 0; i--) begin
      if (one_bit_off(win[i +: 8], sync_byte)) begin
        near_hit = 1'b1;
        near_k   = OffsetW'(i);
      end
    end
`endif

    if (exact_hit) begin
      hit = 1'b1;
      k   = exact_k;
    end else if (near_hit) begin
      hit  = 1'b1;
      corr = 1'b1;
      k    = near_k;
    end
  end

endmodule

// File: rtl/mipi_rx_word_align.sv
// MIPI D-PHY HS word aligner: hunts the sync byte after bit alignment and emits aligned bytes.
// Optional single-bit-error sync acceptance: define MIPI_RX_WORD_ALIGN_SOT_CORR_EN.
module mipi_rx_word_align
  import mipi_rx_word_align_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE = SyncByteDefault,
  parameter int unsigned TIMEOUT_W = 10
) (
  input  logic               SCLK,
  input  logic               RESET,
  input  logic               BIT_ALGN_DONE,
  input  logic               LP_IN,
  input  logic [7:0]         RX_DATA,
  input  logic               RX_VALID,
  output logic [7:0]         BYTE_DATA,
  output logic               BYTE_VALID,
  output logic               SOT_DET,
  output logic               SOT_CORR,
  output logic               WORD_LOCK,
  output logic [OffsetW-1:0] BIT_SHIFT,
  output logic               ALGN_RSTRT,
  output logic               SYNC_ERR
);

  // Miss count at which the next miss ends the hunt (that miss makes 2^TIMEOUT_W-1).
  localparam logic [TIMEOUT_W-1:0] CntLast = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  state_e                 state_q;
  logic [TIMEOUT_W-1:0]   hunt_cnt_q;
  logic [7:0]             prev_q;
  logic [7:0]             byte_data_q;
  logic                   byte_valid_q;
  logic                   sot_det_q;
  logic                   sot_corr_q;
  logic                   word_lock_q;
  logic [OffsetW-1:0]     bit_shift_q;
  logic                   algn_rstrt_q;
  logic                   sync_err_q;

  logic [15:0]            win;
  logic                   match_hit;
  logic                   match_corr;
  logic [OffsetW-1:0]     match_k;

  assign win = {RX_DATA, prev_q};

  mipi_rx_sync_match u_sync_match (
    .win       (win),
    .sync_byte (SYNC_BYTE),
    .hit       (match_hit),
    .corr      (match_corr),
    .k         (match_k)
  );

  always_ff @(posedge SCLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= StIdle;
      hunt_cnt_q   <= '0;
      prev_q       <= 8'h00;
      byte_data_q  <= 8'h00;
      byte_valid_q <= 1'b0;
      sot_det_q    <= 1'b0;
      sot_corr_q   <= 1'b0;
      word_lock_q  <= 1'b0;
      bit_shift_q  <= '0;
      algn_rstrt_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      if (RX_VALID) begin
        prev_q <= RX_DATA;
      end
      sot_det_q    <= 1'b0;
      sot_corr_q   <= 1'b0;
      algn_rstrt_q <= 1'b0;
      sync_err_q   <= 1'b0;

      // Losing bit alignment overrides everything else.
      if (!BIT_ALGN_DONE) begin
        state_q      <= StIdle;
        hunt_cnt_q   <= '0;
        byte_data_q  <= 8'h00;
        byte_valid_q <= 1'b0;
        word_lock_q  <= 1'b0;
        bit_shift_q  <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            state_q <= StLpWait;
          end

          StLpWait: begin
            if (!LP_IN) begin
              state_q    <= StHunt;
              hunt_cnt_q <= '0;
            end
          end

          StHunt: begin
            if (LP_IN) begin
              state_q <= StLpWait;
            end else if (RX_VALID) begin
              if (match_hit) begin
                state_q     <= StLocked;
                sot_det_q   <= 1'b1;
                sot_corr_q  <= match_corr;
                word_lock_q <= 1'b1;
                bit_shift_q <= match_k;
              end else if (hunt_cnt_q == CntLast) begin
                state_q      <= StIdle;
                hunt_cnt_q   <= '0;
                sync_err_q   <= 1'b1;
                algn_rstrt_q <= 1'b1;
              end else begin
                hunt_cnt_q <= hunt_cnt_q + 1'b1;
              end
            end
          end

          StLocked: begin
            if (LP_IN) begin
              state_q      <= StLpWait;
              word_lock_q  <= 1'b0;
              byte_valid_q <= 1'b0;
            end else if (RX_VALID) begin
              byte_data_q  <= win[bit_shift_q +: 8];
              byte_valid_q <= 1'b1;
            end else begin
              byte_valid_q <= 1'b0;
            end
          end

          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign BYTE_DATA  = byte_data_q;
  assign BYTE_VALID = byte_valid_q;
  assign SOT_DET    = sot_det_q;
  assign SOT_CORR   = sot_corr_q;
  assign WORD_LOCK  = word_lock_q;
  assign BIT_SHIFT  = bit_shift_q;
  assign ALGN_RSTRT = algn_rstrt_q;
  assign SYNC_ERR   = sync_err_q;

endmodule

// File: tb/tb_mipi_rx_word_align.sv
// Bench for mipi_rx_word_align: directed sequences plus random traffic checked every cycle
// against a stream-level reference model.
module tb_mipi_rx_word_align;

  localparam logic [7:0]  Sync = 8'hB8;
  localparam int unsigned Tw   = 4;

  localparam int MIdle = 0;
  localparam int MLpw  = 1;
  localparam int MHunt = 2;
  localparam int MLock = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       done = 1'b0;
  logic       lp = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;

  logic [7:0] byte_data;
  logic       byte_valid;
  logic       sot_det;
  logic       sot_corr;
  logic       word_lock;
  logic [2:0] bit_shift;
  logic       algn_rstrt;
  logic       sync_err;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  mipi_rx_word_align #(
    .SYNC_BYTE (Sync),
    .TIMEOUT_W (Tw)
  ) dut (
    .SCLK          (clk),
    .RESET         (rst),
    .BIT_ALGN_DONE (done),
    .LP_IN         (lp),
    .RX_DATA       (rx_data),
    .RX_VALID      (rx_valid),
    .BYTE_DATA     (byte_data),
    .BYTE_VALID    (byte_valid),
    .SOT_DET       (sot_det),
    .SOT_CORR      (sot_corr),
    .WORD_LOCK     (word_lock),
    .BIT_SHIFT     (bit_shift),
    .ALGN_RSTRT    (algn_rstrt),
    .SYNC_ERR      (sync_err)
  );

  always #5 clk = ~clk;

  // Reference model state and expected outputs
  int         m_mode = MIdle;
  int         m_miss = 0;
  logic [7:0] m_prev = 8'h00;
  logic [7:0] e_bd = 8'h00;
  logic       e_bv = 1'b0;
  logic       e_sot = 1'b0;
  logic       e_corr = 1'b0;
  logic       e_lock = 1'b0;
  int         e_shift = 0;
  logic       e_rstrt = 1'b0;
  logic       e_err = 1'b0;

  task automatic find_sync(input logic [15:0] w, output bit found, output bit c, output int kk);
    found = 1'b0;
    c     = 1'b0;
    kk    = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      if (w[i +: 8] == Sync) begin
        found = 1'b1;
        kk    = i;
      end
    end
`ifdef MIPI_RX_WORD_ALIGN_SOT_CORR_EN
    for (int i = 0; i < 8 && !found; i++) begin
      if ($countones(w[i +: 8] ^ Sync) == 1) begin
        found = 1'b1;
        c     = 1'b1;
        kk    = i;
      end
    end
`endif
  endtask

  task automatic model_reset();
    m_mode = MIdle; m_miss = 0; m_prev = 8'h00;
    e_bd = 8'h00; e_bv = 1'b0; e_sot = 1'b0; e_corr = 1'b0;
    e_lock = 1'b0; e_shift = 0; e_rstrt = 1'b0; e_err = 1'b0;
  endtask

  task automatic model_step();
    logic [15:0] w;
    bit          f;
    bit          c;
    int          kk;
    w = {rx_data, m_prev};
    e_sot = 1'b0; e_corr = 1'b0; e_rstrt = 1'b0; e_err = 1'b0;
    if (!done) begin
      m_mode = MIdle; m_miss = 0;
      e_bd = 8'h00; e_bv = 1'b0; e_lock = 1'b0; e_shift = 0;
    end else begin
      case (m_mode)
        MIdle: m_mode = MLpw;
        MLpw: if (!lp) begin m_mode = MHunt; m_miss = 0; end
        MHunt: begin
          if (lp) m_mode = MLpw;
          else if (rx_valid) begin
            find_sync(w, f, c, kk);
            if (f) begin
              m_mode = MLock; e_sot = 1'b1; e_corr = c; e_lock = 1'b1; e_shift = kk;
            end else begin
              m_miss++;
              if (m_miss == (1 << Tw) - 1) begin
                m_mode = MIdle; m_miss = 0; e_err = 1'b1; e_rstrt = 1'b1;
              end
            end
          end
        end
        default: begin
          if (lp) begin
            m_mode = MLpw; e_lock = 1'b0; e_bv = 1'b0;
          end else if (rx_valid) begin
            e_bd = w[e_shift +: 8]; e_bv = 1'b1;
          end else begin
            e_bv = 1'b0;
          end
        end
      endcase
    end
    if (rx_valid) m_prev = rx_data;
  endtask

  always begin
    @(posedge clk or posedge rst);
    if (rst) model_reset();
    else model_step();
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  always begin
    @(negedge clk);
    if (cmp_en) begin
      chk("byte_valid", {7'd0, byte_valid}, {7'd0, e_bv});
      if (e_bv) chk("byte_data", byte_data, e_bd);
      chk("sot_det", {7'd0, sot_det}, {7'd0, e_sot});
      chk("sot_corr", {7'd0, sot_corr}, {7'd0, e_corr});
      chk("word_lock", {7'd0, word_lock}, {7'd0, e_lock});
      chk("bit_shift", {5'd0, bit_shift}, 8'(e_shift));
      chk("algn_rstrt", {7'd0, algn_rstrt}, {7'd0, e_rstrt});
      chk("sync_err", {7'd0, sync_err}, {7'd0, e_err});
    end
  end

  task automatic step(input logic v, input logic [7:0] d, input logic lpv, input logic dn);
    @(negedge clk);
    rx_valid = v;
    rx_data  = d;
    lp       = lpv;
    done     = dn;
  endtask

  task automatic send(input logic [7:0] d);
    step(1'b1, d, 1'b0, 1'b1);
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_byte_valid", {7'd0, byte_valid}, 8'h00);
    chk("rst_word_lock", {7'd0, word_lock}, 8'h00);
    rst = 1'b0;
    cmp_en = 1'b1;

    // Lock at k=3: stream 00,C0,D5 carries B8 in bits 10:3 of {D5,C0}; then payload 5A,C3.
    step(1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    send(8'h00);
    send(8'hC0);
    send(8'hD5);
    send(8'h1A);
    chk("lit_sot_det", {7'd0, sot_det}, 8'h01);
    chk("lit_word_lock", {7'd0, word_lock}, 8'h01);
    chk("lit_bit_shift", {5'd0, bit_shift}, 8'h03);
    send(8'h06);
    chk("lit_payload0", byte_data, 8'h5A);
    chk("lit_payload0_v", {7'd0, byte_valid}, 8'h01);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("lit_payload1", byte_data, 8'hC3);

    // LP rises together with a valid byte: byte dropped, lock lost, offset held.
    step(1'b1, 8'h77, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("lit_drop_v", {7'd0, byte_valid}, 8'h00);
    chk("lit_drop_lock", {7'd0, word_lock}, 8'h00);
    chk("lit_drop_shift", {5'd0, bit_shift}, 8'h03);

    // Hunt timeout after 15 non-sync bytes.
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) begin
      send(8'h00);
      if (i == 14) chk("lit_no_err_early", {7'd0, sync_err}, 8'h00);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("lit_sync_err", {7'd0, sync_err}, 8'h01);
    chk("lit_algn_rstrt", {7'd0, algn_rstrt}, 8'h01);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("lit_sync_err_once", {7'd0, sync_err}, 8'h00);

    // Single-bit-corrupted sync at k=0.
    step(1'b0, 8'h00, 1'b0, 1'b1);
    send(8'hB9);
    send(8'h00);
    step(1'b0, 8'h00, 1'b0, 1'b1);
`ifdef MIPI_RX_WORD_ALIGN_SOT_CORR_EN
    chk("lit_corr_lock", {7'd0, word_lock}, 8'h01);
    chk("lit_corr_pulse", {7'd0, sot_corr}, 8'h01);
`else
    chk("lit_corr_nolock", {7'd0, word_lock}, 8'h00);
    chk("lit_corr_pulse", {7'd0, sot_corr}, 8'h00);
`endif

    // Relock, then reset asynchronously mid-payload.
    step(1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    send(8'h00);
    send(8'hC0);
    send(8'hD5);
    send(8'h1A);
    send(8'h06);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("lit_arst_v", {7'd0, byte_valid}, 8'h00);
    chk("lit_arst_lock", {7'd0, word_lock}, 8'h00);
    chk("lit_arst_shift", {5'd0, bit_shift}, 8'h00);
    chk("lit_arst_data", byte_data, 8'h00);
    step(1'b1, 8'hD5, 1'b1, 1'b1);
    step(1'b1, 8'h1A, 1'b1, 1'b1);
    rst = 1'b0;
    step(1'b1, 8'hC0, 1'b1, 1'b1);
    step(1'b1, 8'hD5, 1'b1, 1'b1);
    step(1'b1, 8'h1A, 1'b1, 1'b1);
    chk("lit_post_rst_v", {7'd0, byte_valid}, 8'h00);

    // Random traffic.
    for (int n = 0; n < 4000; n++) begin
      logic       v;
      logic [7:0] d;
      logic       lpv;
      logic       dn;
      v   = ($urandom_range(0, 9) < 7);
      d   = 8'($urandom);
      case ($urandom_range(0, 15))
        0: d = 8'hB8;
        1: d = 8'hB9;
        2: d = 8'hC0;
        3: d = 8'hD5;
        default: ;
      endcase
      lpv = ($urandom_range(0, 39) == 0) ? ~lp : lp;
      dn  = ($urandom_range(0, 299) != 0);
      step(v, d, lpv, dn);
    end

    step(1'b0, 8'h00, 1'b1, 1'b1);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mipi_rx_word_align.md
MIPI_RX_WORD_ALIGN -- requirements
Module: mipi_rx_word_align

Interface
REQ-001 SHALL have parameter SYNC_BYTE, 8'hB8, HS sync pattern searched after bit alignment.
REQ-002 SHALL have parameter TIMEOUT_W, 10, width of hunt timeout counter in RX_VALID beats.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 SCLK  in  1  byte clock shared with the bit aligner.
REQ-005 RESET  in  1  asynchronous active-high reset.
REQ-006 BIT_ALGN_DONE  in  1  level from bit aligner; eye centred.
REQ-007 LP_IN  in  1  lane in low-power state; HS data invalid.
REQ-008 RX_DATA  in  8  deserialized lane byte, bit 0 received first.
REQ-009 RX_VALID  in  1  RX_DATA qualifier.
REQ-010 BYTE_DATA  out  8  aligned HS payload byte.
REQ-011 BYTE_VALID  out  1  BYTE_DATA qualifier.
REQ-012 SOT_DET  out  1  one-cycle pulse on sync found.
REQ-013 SOT_CORR  out  1  one-cycle pulse on sync found with one corrected bit.
REQ-014 WORD_LOCK  out  1  level, aligned within current HS burst.
REQ-015 BIT_SHIFT  out  3  locked bit offset k.
REQ-016 ALGN_RSTRT  out  1  one-cycle pulse; drives bit aligner BIT_ALGN_RSTRT.
REQ-017 SYNC_ERR  out  1  one-cycle pulse on hunt timeout.

Function
REQ-018 SHALL form window W = {RX_DATA, prev_RX_DATA} (16 bits, prev updated only on RX_VALID); candidate k = W[k+7:k], k = 0..7.
REQ-019 SHALL implement states IDLE, LP_WAIT, HUNT, LOCKED.
REQ-020 IDLE -> LP_WAIT when BIT_ALGN_DONE = 1.
REQ-021 LP_WAIT -> HUNT when LP_IN = 0; hunt counter cleared on entry.
REQ-022 HUNT: on RX_VALID with any candidate equal to SYNC_BYTE -> LOCKED; lowest k wins; next cycle SOT_DET = 1, WORD_LOCK = 1, BIT_SHIFT = k.
REQ-023 HUNT: each RX_VALID without match increments counter; at 2^TIMEOUT_W-1 -> IDLE, SYNC_ERR and ALGN_RSTRT pulse together next cycle.
REQ-024 LOCKED: for each RX_VALID, BYTE_DATA = W[BIT_SHIFT+7:BIT_SHIFT], BYTE_VALID = 1, latency exactly one cycle; sync byte itself never output.
REQ-025 LOCKED -> LP_WAIT when LP_IN = 1; WORD_LOCK and BYTE_VALID clear next cycle; an RX_VALID in that same cycle is dropped.
REQ-026 HUNT -> LP_WAIT when LP_IN = 1 (LP_IN wins over a simultaneous match); no SYNC_ERR.
REQ-027 BIT_ALGN_DONE = 0 in any state -> IDLE next cycle, outputs return to reset values; overrides all other transitions.
REQ-028 BIT_SHIFT SHALL hold its value through LP_WAIT until the next lock.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 RESET = 1 SHALL force state IDLE, counter 0, prev_RX_DATA 0, all outputs 0, asynchronously, including mid-burst.
REQ-031 First lock after reset release SHALL require a fresh LP_IN low transition through LP_WAIT.

Configuration
REQ-032 Macro MIPI_RX_WORD_ALIGN_SOT_CORR_EN defined: if no exact match at any k, a candidate at Hamming distance 1 from SYNC_BYTE (lowest k) SHALL lock, pulsing SOT_DET and SOT_CORR.
REQ-033 Macro undefined: exact match only; SOT_CORR tied 0.

Structure
REQ-034 Package mipi_rx_word_align_pkg SHALL hold the state enum, default SYNC_BYTE, and the offset width constant (3).
REQ-035 Sub-module mipi_rx_sync_match SHALL take W and SYNC_BYTE and return hit, corr, k.

Verification
REQ-036 DONE=1, LP_IN 1->0, bytes 00, then sync shifted by k=3 -> SOT_DET pulse, WORD_LOCK=1, BIT_SHIFT=3, subsequent payload 5A,C3 reproduced on BYTE_DATA one cycle after RX_VALID.
REQ-037 TIMEOUT_W=4, 15 valid non-sync bytes in HUNT -> SYNC_ERR and ALGN_RSTRT pulse once, state IDLE.
REQ-038 LOCKED, LP_IN rises with RX_VALID=1 -> that byte dropped, WORD_LOCK=0 next cycle, BIT_SHIFT held.
REQ-039 RESET asserted mid-payload -> all outputs 0 immediately; no BYTE_VALID until new LP_IN low and sync.
REQ-040 Sync 0xB9 (one bit flipped) at k=0 -> with macro SOT_DET=SOT_CORR=1; without macro no lock, counter advances.
